// File: rtl/ps_pkg.sv
// Shared definitions for the rotating multi-grant selector family.
package ps_pkg;

  localparam int PS_REQ_N     = 16;
  localparam int PS_GNT_W     = 2;
  // Widest grant index a slot record can carry (REQ_N up to 256).
  localparam int PS_IDX_MAX_W = 8;

  typedef struct packed {
    logic                    valid;
    logic [PS_IDX_MAX_W-1:0] idx;
  } gnt_slot_t;

  // Step one position down the priority ring, wrapping 0 -> n-1.
  function automatic int unsigned rr_dec(input int unsigned x, input int unsigned n);
    return (x == 0) ? n - 1 : x - 1;
  endfunction

endpackage

// File: rtl/ps_rr_sel_if.sv
// Request/grant bundle between ps_rr_sel and its requesters/consumer.
interface ps_rr_sel_if
  import ps_pkg::*;
#(
  parameter int REQ_N = PS_REQ_N,
  parameter int GNT_W = PS_GNT_W
);
  localparam int IDX_W = $clog2(REQ_N);

  logic                        flush;
  logic [REQ_N-1:0]            req;
  logic                        en;
  logic                        ready;
  logic [GNT_W-1:0]            gnt_valid;
  logic [GNT_W-1:0][IDX_W-1:0] gnt_idx;
  logic [REQ_N-1:0]            gnt_mask;
  logic                        req_up;

  // Selector side.
  modport master (input flush, req, en, ready,
                  output gnt_valid, gnt_idx, gnt_mask, req_up);
  // Requester / consumer side.
  modport slave  (output flush, req, en, ready,
                  input gnt_valid, gnt_idx, gnt_mask, req_up);
endinterface

// File: rtl/ps_rr_pick.sv
// First set bit of mask in descending wrapped order starting at ptr.
module ps_rr_pick #(
  parameter int REQ_N = 16
) (
  input  logic [REQ_N-1:0]         mask,
  input  logic [$clog2(REQ_N)-1:0] ptr,
  output logic                     valid,
  output logic [$clog2(REQ_N)-1:0] idx
);
  localparam int IDX_W = $clog2(REQ_N);

  // Scan lowest priority first so the highest-priority hit is written last;
  // REQ_N is a power of two, so index arithmetic wraps for free.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = REQ_N - 1; i >= 0; i--) begin
      if (mask[ptr - IDX_W'(i)]) begin
        valid = 1'b1;
        idx   = ptr - IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ps_rr_sel.sv
// Multi-grant rotating priority selector with registered, handshaked grants.
// PS_RR_EN defined: priority pointer rotates past each accepted bundle.
// PS_RR_EN undefined: pointer fixed at REQ_N-1 (highest index first).
module ps_rr_sel
  import ps_pkg::*;
#(
  parameter int REQ_N = PS_REQ_N,
  parameter int GNT_W = PS_GNT_W
) (
  input logic          clock,
  input logic          reset_n,
  ps_rr_sel_if.master  bus
);
  localparam int IDX_W = $clog2(REQ_N);

  logic [IDX_W-1:0]            ptr;
  logic [GNT_W:0][REQ_N-1:0]   mask_c;
  logic [GNT_W-1:0]            pick_v;
  logic [GNT_W-1:0][IDX_W-1:0] pick_idx;
  gnt_slot_t [GNT_W-1:0]       pick;
  logic [REQ_N-1:0]            pick_mask;
  logic                        any_gnt;
  logic [IDX_W-1:0]            last_idx;
  logic                        load;

  assign bus.req_up = |bus.req;
  assign load       = !(|bus.gnt_valid) || bus.ready;

  // Slot k searches the requests left after slots 0..k-1 took theirs.
  assign mask_c[0] = bus.req;
  for (genvar k = 0; k < GNT_W; k++) begin : g_slot
    ps_rr_pick #(.REQ_N(REQ_N)) u_pick (
      .mask  (mask_c[k]),
      .ptr   (ptr),
      .valid (pick_v[k]),
      .idx   (pick_idx[k])
    );
    assign mask_c[k+1] = mask_c[k] & ~({{(REQ_N-1){1'b0}}, pick_v[k]} << pick_idx[k]);
    assign pick[k]     = '{valid: pick_v[k], idx: PS_IDX_MAX_W'(pick_idx[k])};
  end

  // Everything removed along the chain is exactly the set of granted bits.
  assign pick_mask = mask_c[0] & ~mask_c[GNT_W];

  // Lowest-priority grant of this pick; slots fill in order so the last valid one wins.
  always_comb begin
    any_gnt  = 1'b0;
    last_idx = '0;
    for (int k = 0; k < GNT_W; k++) begin
      if (pick[k].valid) begin
        any_gnt  = 1'b1;
        last_idx = IDX_W'(pick[k].idx);
      end
    end
  end

`ifdef PS_RR_EN
  // Move priority to just past the last grant whenever a non-empty pick is loaded.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      ptr <= IDX_W'(REQ_N - 1);
    else if (bus.flush)
      ptr <= IDX_W'(REQ_N - 1);
    else if (load && bus.en && any_gnt)
      ptr <= IDX_W'(rr_dec(32'(last_idx), REQ_N));
  end
`else
  assign ptr = IDX_W'(REQ_N - 1);
`endif

  // Grant bundle: flush clears, load takes the new pick (or clears if disabled),
  // otherwise the bundle is stalled waiting for ready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.gnt_valid <= '0;
      bus.gnt_idx   <= '0;
      bus.gnt_mask  <= '0;
    end else if (bus.flush) begin
      bus.gnt_valid <= '0;
      bus.gnt_idx   <= '0;
      bus.gnt_mask  <= '0;
    end else if (load) begin
      if (bus.en) begin
        bus.gnt_valid <= pick_v;
        bus.gnt_idx   <= pick_idx;
        bus.gnt_mask  <= pick_mask;
      end else begin
        bus.gnt_valid <= '0;
        bus.gnt_idx   <= '0;
        bus.gnt_mask  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps_rr_sel.sv
// Directed bench for ps_rr_sel (REQ_N=8, GNT_W=2); expectations follow PS_RR_EN.
module tb_ps_rr_sel;
  localparam int REQ_N = 8;
  localparam int GNT_W = 2;
`ifdef PS_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  ps_rr_sel_if #(.REQ_N(REQ_N), .GNT_W(GNT_W)) bus ();

  ps_rr_sel #(.REQ_N(REQ_N), .GNT_W(GNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Whole bundle plus pointer: valid bits, {slot1,slot0} indices, mask, ptr.
  task automatic chk_b(input string tag, input logic [1:0] v, input logic [2:0] i1,
                       input logic [2:0] i0, input logic [7:0] m, input logic [2:0] p);
    chk({tag, ".v"},    32'(bus.gnt_valid), 32'(v));
    chk({tag, ".idx"},  32'(bus.gnt_idx),   32'({i1, i0}));
    chk({tag, ".mask"}, 32'(bus.gnt_mask),  32'(m));
    chk({tag, ".ptr"},  32'(dut.ptr),       32'(p));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.req   = '0;
    bus.en    = 1'b0;
    bus.ready = 1'b0;

    // Reset state.
    repeat (2) tick();
    chk_b("rst", 2'b00, 3'd0, 3'd0, 8'h00, 3'd7);
    chk("rst.up", 32'(bus.req_up), 32'd0);

    // Release reset with two requests at the ring boundary.
    bus.req = 8'h81; bus.en = 1'b1; bus.ready = 1'b1;
    #1;
    chk("up", 32'(bus.req_up), 32'd1);
    reset_n = 1'b1;
    tick();
    chk_b("first", 2'b11, 3'd0, 3'd7, 8'h81, 3'd7);

    // Rotation with all requesters active.
    bus.req = 8'hFF;
    tick(); chk_b("rot0", 2'b11, 3'd6, 3'd7, 8'hC0, RR ? 3'd5 : 3'd7);
    tick(); chk_b("rot1", 2'b11, RR ? 3'd4 : 3'd6, RR ? 3'd5 : 3'd7, RR ? 8'h30 : 8'hC0, RR ? 3'd3 : 3'd7);
    tick(); chk_b("rot2", 2'b11, RR ? 3'd2 : 3'd6, RR ? 3'd3 : 3'd7, RR ? 8'h0C : 8'hC0, RR ? 3'd1 : 3'd7);
    tick(); chk_b("rot3", 2'b11, RR ? 3'd0 : 3'd6, RR ? 3'd1 : 3'd7, RR ? 8'h03 : 8'hC0, 3'd7);
    tick(); chk_b("rot4", 2'b11, 3'd6, 3'd7, 8'hC0, RR ? 3'd5 : 3'd7);

    // Stall: bundle and pointer hold while req changes underneath.
    bus.ready = 1'b0; bus.req = 8'h0F;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_b("stall", 2'b11, 3'd6, 3'd7, 8'hC0, RR ? 3'd5 : 3'd7);
    end
    bus.ready = 1'b1;
    tick(); chk_b("resume", 2'b11, 3'd2, 3'd3, 8'h0C, RR ? 3'd1 : 3'd7);

    // Single request leaves slot 1 empty.
    bus.req = 8'h04;
    tick(); chk_b("single", 2'b01, 3'd0, 3'd2, 8'h04, RR ? 3'd1 : 3'd7);

    // No requests: empty bundle, pointer holds.
    bus.req = 8'h00;
    tick(); chk_b("empty", 2'b00, 3'd0, 3'd0, 8'h00, RR ? 3'd1 : 3'd7);
    chk("empty.up", 32'(bus.req_up), 32'd0);

    // en=0 on a load clears outputs and keeps pointer.
    bus.req = 8'h30;
    tick(); chk_b("pre_en", 2'b11, 3'd4, 3'd5, 8'h30, RR ? 3'd3 : 3'd7);
    bus.en = 1'b0; bus.req = 8'hFF;
    tick(); chk_b("en0", 2'b00, 3'd0, 3'd0, 8'h00, RR ? 3'd3 : 3'd7);

    // Flush beats a stall and resets the pointer.
    bus.en = 1'b1;
    tick(); chk_b("pre_fl", 2'b11, RR ? 3'd2 : 3'd6, RR ? 3'd3 : 3'd7, RR ? 8'h0C : 8'hC0, RR ? 3'd1 : 3'd7);
    bus.ready = 1'b0; bus.flush = 1'b1;
    tick(); chk_b("flush", 2'b00, 3'd0, 3'd0, 8'h00, 3'd7);

    // Empty bundle loads even with ready low.
    bus.flush = 1'b0; bus.req = 8'h81;
    tick(); chk_b("empty_ld", 2'b11, 3'd0, 3'd7, 8'h81, 3'd7);

    // Asynchronous reset takes effect between edges.
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk_b("async_rst", 2'b00, 3'd0, 3'd0, 8'h00, 3'd7);
    tick();
    reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
